// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the UART stream FIFO.
package fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GUARD = 1'b1
    } drain_state_t;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int level_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    // Guard counter must hold BUSY_LAT itself, not just BUSY_LAT-1.
    function automatic int count_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ptr_width(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_stream_fifo.sv
// Parametrised FIFO feeding a busy-gated serial sink; the drain FSM holds off
// after each pop so the sink's busy latency can never cause a double issue.
module uart_stream_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int BUSY_LAT  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          flush,
    input  logic                          clr_ovf,
    input  logic                          sink_busy,
    output logic [WIDTH-1:0]              data_out,
    output logic                          out_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam int CW = count_width(BUSY_LAT);

    drain_state_t   state, state_next;
    logic [CW-1:0]  guard_cnt, guard_cnt_next;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level_next;
    logic [WIDTH-1:0] rd_data;
    logic           do_write, do_pop;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_write),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Decisions use the registered flags, so a word written into an empty
    // FIFO is never popped in the same cycle.
    always_comb begin
        do_write       = wr_en && !full && !flush;
        do_pop         = 1'b0;
        state_next     = state;
        guard_cnt_next = guard_cnt;
        case (state)
            ST_IDLE: begin
                if (!empty && !sink_busy) begin
                    do_pop         = 1'b1;
                    state_next     = ST_GUARD;
                    guard_cnt_next = CW'(BUSY_LAT);
                end
            end
            ST_GUARD: begin
                guard_cnt_next = guard_cnt - CW'(1);
                if (guard_cnt <= CW'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            do_pop         = 1'b0;
            state_next     = ST_IDLE;
            guard_cnt_next = '0;
        end
    end

    always_comb begin
        level_next = level;
        case ({do_write, do_pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
        if (flush) begin
            level_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_cnt_next;
        end
    end

    // Flags are registered from the next level so they always agree with level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_write) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop)   rd_ptr <= rd_ptr + PW'(1);
            end
            level       <= level_next;
            full        <= (level_next == LW'(DEPTH));
            empty       <= (level_next == '0);
            almost_full <= (level_next >= LW'(AF_THRESH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= do_pop;
            if (do_pop) begin
                data_out <= rd_data;
            end
            if (wr_en && full && !flush) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_stream_fifo.sv
// Self-checking bench for uart_stream_fifo against a queue-based reference model.
module tb_uart_stream_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int BL    = 2;

    logic       clk = 1'b0;
    logic       reset, wr_en, flush, clr_ovf, sink_busy;
    logic [7:0] data_in, data_out;
    logic       out_valid, full, empty, almost_full, overflow;
    logic [3:0] level;

    int passed = 0;
    int total  = 0;

    // Reference model: contents as a queue, pop timing as cycle arithmetic.
    logic [7:0]  q[$];
    bit          m_ovf, m_vld;
    logic [7:0]  m_dout;
    int unsigned cyc, earliest;

    always #5 clk = ~clk;

    uart_stream_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .BUSY_LAT  (BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .flush       (flush),
        .clr_ovf     (clr_ovf),
        .sink_busy   (sink_busy),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow)
    );

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_vld    = 1'b0;
        m_dout   = 8'h00;
        cyc      = 0;
        earliest = 0;
    endtask

    function automatic bit model_pop(input bit busy, input bit fl);
        return !fl && (q.size() > 0) && !busy && (cyc >= earliest);
    endfunction

    // Drive one cycle of inputs, advance the model, sample 1ns after the edge.
    task automatic tick(input bit wr, input logic [7:0] din, input bit fl,
                        input bit clr, input bit busy);
        bit p, full_m;
        p      = model_pop(busy, fl);
        full_m = (q.size() == DEPTH);
        wr_en = wr; data_in = din; flush = fl; clr_ovf = clr; sink_busy = busy;
        if (wr && !fl && full_m) m_ovf = 1'b1;
        else if (clr)            m_ovf = 1'b0;
        if (fl) begin
            q.delete();
            m_vld    = 1'b0;
            earliest = cyc + 1;
        end else begin
            if (p) begin
                m_dout   = q.pop_front();
                m_vld    = 1'b1;
                earliest = cyc + BL + 1;
            end else begin
                m_vld = 1'b0;
            end
            if (wr && !full_m) q.push_back(din);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; wr_en = 0; data_in = 0; flush = 0; clr_ovf = 0; sink_busy = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        total++;
        if (level !== 4'd5) $display("[TB] FAIL reset_prefill level got %0d want 5", level);
        else passed++;
        n = 0;
        while (!m_vld && n < 5) begin tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); n++; end
        total++;
        if (out_valid !== 1'b1) $display("[TB] FAIL reset_middrain out_valid got %b want 1", out_valid);
        else passed++;
        reset = 1'b1;
        #2;
        total++;
        if ({data_out, out_valid, full, empty, almost_full, level, overflow} !==
            {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0})
            $display("[TB] FAIL reset_async dout=%h vld=%b full=%b empty=%b af=%b lvl=%0d ovf=%b want 00 0 0 1 0 0 0",
                     data_out, out_valid, full, empty, almost_full, level, overflow);
        else passed++;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        sink_busy = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
            total++;
            if (level !== 4'(i) || almost_full !== (i >= 6) || full !== (i == 8) || empty !== 1'b0)
                $display("[TB] FAIL fill_%0d lvl=%0d af=%b full=%b empty=%b want %0d %b %b 0",
                         i, level, almost_full, full, empty, i, (i >= 6), (i == 8));
            else passed++;
        end
        tick(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        total++;
        if (overflow !== 1'b1 || level !== 4'd8)
            $display("[TB] FAIL fill_overflow ovf=%b lvl=%0d want 1 8", overflow, level);
        else passed++;
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        total++;
        if (overflow !== 1'b0) $display("[TB] FAIL fill_clr_ovf got %b want 0", overflow);
        else passed++;
    endtask

    task automatic test_drain_order();
        int last, n;
        last = 0; n = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            total++;
            if (out_valid !== m_vld) $display("[TB] FAIL drain_vld cycle %0d got %b want %b", k, out_valid, m_vld);
            else passed++;
            if (out_valid === 1'b1) begin
                total++;
                if (data_out !== 8'(n + 1)) $display("[TB] FAIL drain_data got %h want %h", data_out, 8'(n + 1));
                else passed++;
                if (n > 0) begin
                    total++;
                    if (k - last != 3) $display("[TB] FAIL drain_gap got %0d want 3", k - last);
                    else passed++;
                end
                last = k;
                n++;
            end
        end
        total++;
        if (n != 8 || empty !== 1'b1) $display("[TB] FAIL drain_count pops=%0d empty=%b want 8 1", n, empty);
        else passed++;
    endtask

    task automatic test_concurrent();
        logic [7:0] next_in, exp_out;
        bit p;
        int pops;
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
        next_in = 8'h14; exp_out = 8'h10; pops = 0;
        for (int k = 0; k < 40; k++) begin
            p = model_pop(1'b0, 1'b0);
            tick(p, next_in, 1'b0, 1'b0, 1'b0);
            if (p) next_in++;
            total++;
            if (level !== 4'd4) $display("[TB] FAIL concurrent_level got %0d want 4", level);
            else passed++;
            if (out_valid === 1'b1) begin
                total++;
                if (data_out !== exp_out) $display("[TB] FAIL concurrent_data got %h want %h", data_out, exp_out);
                else passed++;
                exp_out++;
                pops++;
            end
        end
        total++;
        if (pops < 12) $display("[TB] FAIL concurrent_pops got %0d want >=12", pops);
        else passed++;
    endtask

    task automatic test_busy_mask();
        int n;
        n = 0;
        while (!m_vld && n < 10) begin tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); n++; end
        total++;
        if (out_valid !== 1'b1) $display("[TB] FAIL busy_first_pop got %b want 1 (timeout)", out_valid);
        else passed++;
        for (int k = 0; k < 2; k++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            total++;
            if (out_valid !== 1'b0) $display("[TB] FAIL busy_hold cycle %0d out_valid got %b want 0", k, out_valid);
            else passed++;
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || data_out !== m_dout)
            $display("[TB] FAIL busy_release vld=%b dout=%h want 1 %h", out_valid, data_out, m_dout);
        else passed++;
    endtask

    task automatic test_flush();
        int n;
        n = 0;
        while (q.size() < DEPTH && n < 20) begin tick(1'b1, 8'(8'h60 + n), 1'b0, 1'b0, 1'b1); n++; end
        tick(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        total++;
        if (overflow !== 1'b1) $display("[TB] FAIL flush_pre_ovf got %b want 1", overflow);
        else passed++;
        n = 0;
        while (q.size() > 5 && n < 30) begin tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); n++; end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        total++;
        if (level !== 4'd5) $display("[TB] FAIL flush_pre_level got %0d want 5", level);
        else passed++;
        tick(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        total++;
        if (level !== 4'd0 || empty !== 1'b1 || overflow !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL flush_state lvl=%0d empty=%b ovf=%b vld=%b want 0 1 1 0",
                     level, empty, overflow, out_valid);
        else passed++;
        tick(1'b1, 8'h5C, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!m_vld && n < 10) begin tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); n++; end
        total++;
        if (out_valid !== 1'b1 || data_out !== 8'h5C)
            $display("[TB] FAIL flush_after vld=%b dout=%h want 1 5c", out_valid, data_out);
        else passed++;
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [16:0] got, exp;
        for (int k = 0; k < 500; k++) begin
            tick(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 4));
            got = {out_valid, data_out, full, empty, almost_full, overflow, level};
            exp = {m_vld, m_dout, (q.size() == DEPTH), (q.size() == 0), (q.size() >= AF),
                   m_ovf, 4'(q.size())};
            total++;
            if (got !== exp) $display("[TB] FAIL random_state cycle %0d got %h want %h", k, got, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_order();
        test_concurrent();
        test_busy_mask();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
